// File: rtl/jpeg_cone_pkg.sv
// Shared constants and per-lane stage payload types for the jpeg_cone_pipe datapath.
package jpeg_cone_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  // One bit-lane of the S1 register: inverted a/b plus c, d, e passed through
  typedef struct packed {
    logic c;
    logic d;
    logic e;
    logic t5;
    logic t6;
  } s1_lane_t;

  typedef struct packed {
    logic c;
    logic d;
    logic t9;
  } s2_lane_t;

endpackage

// File: rtl/jpeg_cone_stage.sv
// Generic valid/ready pipeline register: loads when empty or unloading in the same cycle.
module jpeg_cone_stage #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          w_unload;
  logic          w_load;

  assign w_unload = r_valid & i_ready;
  assign o_ready  = ~r_valid | w_unload;
  assign w_load   = i_valid & o_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (w_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/jpeg_cone_pipe.sv
// Three-stage valid/ready pipeline evaluating a per-lane NOR4/AND/OAI21/MAJ cone.
module jpeg_cone_pipe
  import jpeg_cone_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LEGACY = 0,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic [WIDTH-1:0] in_e,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [CNT_W-1:0] out_cnt
);

  s1_lane_t [WIDTH-1:0] w_s1_d;
  s1_lane_t [WIDTH-1:0] w_s1_q;
  s2_lane_t [WIDTH-1:0] w_s2_d;
  s2_lane_t [WIDTH-1:0] w_s2_q;
  logic     [WIDTH-1:0] w_y_d;
  logic                 w_v1;
  logic                 w_v2;
  logic                 w_rdy2;
  logic                 w_rdy3;
  logic [CNT_W-1:0]     r_cnt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic w_t8;
    logic w_g;
    logic w_t11;

    assign w_s1_d[i].c  = in_c[i];
    assign w_s1_d[i].d  = in_d[i];
    assign w_s1_d[i].e  = in_e[i];
    assign w_s1_d[i].t5 = ~in_a[i];
    assign w_s1_d[i].t6 = ~in_b[i];

    // NOR4 keeps the duplicated t5 input of the original netlist
    assign w_t8 = ~(w_s1_q[i].t5 | w_s1_q[i].t5 | w_s1_q[i].e | w_s1_q[i].t6);

    if (LEGACY != 0) begin : g_legacy
      assign w_g = w_s1_q[i].t5;
    end else begin : g_new
      assign w_g = ~w_s1_q[i].e;
    end

    assign w_s2_d[i].c  = w_s1_q[i].c;
    assign w_s2_d[i].d  = w_s1_q[i].d;
    assign w_s2_d[i].t9 = w_t8 & w_g;

    assign w_t11    = ~((~w_s2_q[i].t9 | w_s2_q[i].d) & w_s2_q[i].c);
    assign w_y_d[i] = (w_t11 & w_s2_q[i].d) | (w_t11 & w_s2_q[i].c) |
                      (w_s2_q[i].d & w_s2_q[i].c);
  end

  jpeg_cone_stage #(.DW(WIDTH * $bits(s1_lane_t))) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_s1_d),
    .o_valid (w_v1),
    .i_ready (w_rdy2),
    .o_data  (w_s1_q)
  );

  jpeg_cone_stage #(.DW(WIDTH * $bits(s2_lane_t))) u_s2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_v1),
    .o_ready (w_rdy2),
    .i_data  (w_s2_d),
    .o_valid (w_v2),
    .i_ready (w_rdy3),
    .o_data  (w_s2_q)
  );

  jpeg_cone_stage #(.DW(WIDTH)) u_s3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_v2),
    .o_ready (w_rdy3),
    .i_data  (w_y_d),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (out_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (out_valid && out_ready) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_cnt = r_cnt;

endmodule

// File: tb/tb_jpeg_cone_pipe.sv
// Bench for jpeg_cone_pipe: three instances (new gating, legacy gating, 4-bit counter) on shared stimulus.
module tb_jpeg_cone_pipe;

  typedef struct {
    logic [3:0] a, b, c, d, e;
    int cyc;
  } beat_t;

  typedef struct {
    logic [3:0] y;
    int cyc;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready;
  logic [3:0] in_a, in_b, in_c, in_d, in_e;
  logic       rdy0, rdy1, rdy2, ov0, ov1, ov2;
  logic [3:0] y0, y1, y2;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  beat_t acc_q[$];
  obs_t  oq0[$], oq1[$], oq2[$];

  always #5 clk = ~clk;

  jpeg_cone_pipe #(.WIDTH(4), .LEGACY(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e),
    .out_valid(ov0), .out_ready(out_ready), .out_y(y0), .out_cnt(cnt0));

  jpeg_cone_pipe #(.WIDTH(4), .LEGACY(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e),
    .out_valid(ov1), .out_ready(out_ready), .out_y(y1), .out_cnt(cnt1));

  jpeg_cone_pipe #(.WIDTH(4), .LEGACY(0), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e),
    .out_valid(ov2), .out_ready(out_ready), .out_y(y2), .out_cnt(cnt2));

  // Reference: legacy gating forces y = d; otherwise t9 = a & b & ~e feeds OAI21 then MAJ
  function automatic logic [3:0] ref_y(input beat_t bt, input bit legacy);
    logic [3:0] t9, t11;
    t9  = bt.a & bt.b & ~bt.e;
    t11 = ~((~t9 | bt.d) & bt.c);
    if (legacy) return bt.d;
    return (t11 & bt.d) | (t11 & bt.c) | (bt.d & bt.c);
  endfunction

  task automatic rand_data();
    in_a = 4'($urandom); in_b = 4'($urandom); in_c = 4'($urandom);
    in_d = 4'($urandom); in_e = 4'($urandom);
  endtask

  // One clock: sample handshakes mid-cycle, then move to just after the next edge
  task automatic step();
    beat_t bt;
    obs_t  ob;
    @(negedge clk);
    if (in_valid && rdy0) begin
      bt.a = in_a; bt.b = in_b; bt.c = in_c; bt.d = in_d; bt.e = in_e; bt.cyc = cyc;
      acc_q.push_back(bt);
    end
    ob.cyc = cyc;
    if (ov0 && out_ready) begin ob.y = y0; oq0.push_back(ob); end
    if (ov1 && out_ready) begin ob.y = y1; oq1.push_back(ob); end
    if (ov2 && out_ready) begin ob.y = y2; oq2.push_back(ob); end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    acc_q.delete(); oq0.delete(); oq1.delete(); oq2.delete();
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b1; rand_data();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", ov0); end
    n_cmp++; if (y0 !== 4'h0) begin n_bad++; $display("FAIL reset_out_y got=%h exp=0", y0); end
    n_cmp++; if (cnt0 !== 16'd0) begin n_bad++; $display("FAIL reset_out_cnt got=%0d exp=0", cnt0); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", rdy0); end
  endtask

  task automatic test_stream();
    apply_reset();
    in_valid = 1'b1; in_a = 4'hF; in_b = 4'hF; in_e = 4'h0; in_c = 4'hF; in_d = 4'h0;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    n_cmp++; if (oq0.size() !== 1) begin n_bad++; $display("FAIL stream_count got=%0d exp=1", oq0.size()); end
    if (oq0.size() == 1 && acc_q.size() == 1) begin
      n_cmp++; if (oq0[0].y !== 4'hF) begin n_bad++; $display("FAIL stream_y got=%h exp=F", oq0[0].y); end
      n_cmp++; if (oq0[0].cyc - acc_q[0].cyc !== 3) begin
        n_bad++; $display("FAIL stream_latency got=%0d exp=3", oq0[0].cyc - acc_q[0].cyc); end
    end
    n_cmp++; if (cnt0 !== 16'd1) begin n_bad++; $display("FAIL stream_cnt got=%0d exp=1", cnt0); end
    // e all ones gates t9 off
    in_valid = 1'b1; in_e = 4'hF;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    n_cmp++; if (oq0.size() !== 2) begin n_bad++; $display("FAIL gated_count got=%0d exp=2", oq0.size()); end
    else begin
      n_cmp++; if (oq0[1].y !== 4'h0) begin n_bad++; $display("FAIL gated_y got=%h exp=0", oq0[1].y); end
    end
  endtask

  task automatic test_legacy_random();
    int steps = 0;
    apply_reset();
    while (acc_q.size() < 100 && steps < 2000) begin
      rand_data();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      steps++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();
    n_cmp++; if (acc_q.size() !== 100) begin n_bad++; $display("FAIL legacy_accepted got=%0d exp=100", acc_q.size()); end
    n_cmp++; if (oq1.size() !== acc_q.size()) begin n_bad++; $display("FAIL legacy_delivered got=%0d exp=%0d", oq1.size(), acc_q.size()); end
    n_cmp++; if (oq0.size() !== acc_q.size()) begin n_bad++; $display("FAIL new_delivered got=%0d exp=%0d", oq0.size(), acc_q.size()); end
    for (int i = 0; i < acc_q.size() && i < oq1.size(); i++) begin
      n_cmp++; if (oq1[i].y !== acc_q[i].d) begin n_bad++; $display("FAIL legacy_y[%0d] got=%h exp=%h", i, oq1[i].y, acc_q[i].d); end
    end
    for (int i = 0; i < acc_q.size() && i < oq0.size(); i++) begin
      n_cmp++; if (oq0[i].y !== ref_y(acc_q[i], 1'b0)) begin
        n_bad++; $display("FAIL new_y[%0d] got=%h exp=%h", i, oq0[i].y, ref_y(acc_q[i], 1'b0)); end
    end
    n_cmp++; if (cnt1 !== 16'd100) begin n_bad++; $display("FAIL legacy_cnt got=%0d exp=100", cnt1); end
  endtask

  task automatic test_backpressure();
    logic [3:0] held = 4'h0;
    apply_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_data();
      step();
      if (i == 2) held = y0;
      if (i > 2) begin
        n_cmp++; if (ov0 !== 1'b1 || y0 !== held) begin
          n_bad++; $display("FAIL stall_hold[%0d] got=%b/%h exp=1/%h", i, ov0, y0, held); end
      end
    end
    n_cmp++; if (acc_q.size() !== 3) begin n_bad++; $display("FAIL stall_accepted got=%0d exp=3", acc_q.size()); end
    n_cmp++; if (rdy0 !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready got=%b exp=0", rdy0); end
    if (acc_q.size() > 0) begin
      n_cmp++; if (held !== ref_y(acc_q[0], 1'b0)) begin
        n_bad++; $display("FAIL stall_value got=%h exp=%h", held, ref_y(acc_q[0], 1'b0)); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) step();
    n_cmp++; if (oq0.size() !== 3) begin n_bad++; $display("FAIL release_count got=%0d exp=3", oq0.size()); end
    for (int i = 0; i < 3 && i < oq0.size() && i < acc_q.size(); i++) begin
      n_cmp++; if (oq0[i].y !== ref_y(acc_q[i], 1'b0) || oq0[i].cyc !== oq0[0].cyc + i) begin
        n_bad++; $display("FAIL release[%0d] got=%h@%0d exp=%h@%0d", i, oq0[i].y, oq0[i].cyc, ref_y(acc_q[i], 1'b0), oq0[0].cyc + i); end
    end
    n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got=%b exp=1", rdy0); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    repeat (17) begin rand_data(); step(); end
    in_valid = 1'b0;
    repeat (6) step();
    n_cmp++; if (acc_q.size() !== 17) begin n_bad++; $display("FAIL b2b_accepted got=%0d exp=17", acc_q.size()); end
    n_cmp++; if (oq2.size() !== 17) begin n_bad++; $display("FAIL b2b_delivered got=%0d exp=17", oq2.size()); end
    for (int i = 0; i < acc_q.size() && i < oq2.size(); i++) begin
      n_cmp++; if (oq2[i].y !== ref_y(acc_q[i], 1'b0) || oq2[i].cyc !== acc_q[i].cyc + 3) begin
        n_bad++; $display("FAIL b2b[%0d] got=%h@%0d exp=%h@%0d", i, oq2[i].y, oq2[i].cyc, ref_y(acc_q[i], 1'b0), acc_q[i].cyc + 3); end
    end
    n_cmp++; if (cnt2 !== 4'd1) begin n_bad++; $display("FAIL wrap_cnt got=%0d exp=1", cnt2); end
    n_cmp++; if (cnt0 !== 16'd17) begin n_bad++; $display("FAIL wide_cnt got=%0d exp=17", cnt0); end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    rand_data(); in_c = 4'hF; in_d = 4'hF;
    step();
    rand_data();
    step();
    in_valid = 1'b0;
    step();
    n_cmp++; if (ov0 !== 1'b1 || y0 !== 4'hF) begin
      n_bad++; $display("FAIL inflight_out got=%b/%h exp=1/F", ov0, y0); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (ov0 !== 1'b0 || y0 !== 4'h0) begin
      n_bad++; $display("FAIL async_clear got=%b/%h exp=0/0", ov0, y0); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    acc_q.delete(); oq0.delete(); oq1.delete(); oq2.delete();
    n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready got=%b exp=1", rdy0); end
    out_ready = 1'b1;
    repeat (6) step();
    n_cmp++; if (oq0.size() !== 0) begin n_bad++; $display("FAIL stale_output got=%0d exp=0", oq0.size()); end
    n_cmp++; if (cnt0 !== 16'd0) begin n_bad++; $display("FAIL post_reset_cnt got=%0d exp=0", cnt0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_e = '0;
    test_reset();
    test_stream();
    test_legacy_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
